cell_pixel_scan: RTL and testbench

CELL_PIXEL_SCAN -- requirements
Module: cell_pixel_scan

---
 rtl/cell_pixel_scan_if.sv | 25 ++
 rtl/cell_pixel_scan.sv | 138 +++++++++++++
 tb/tb_cell_pixel_scan.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cell_pixel_scan_if.sv
// Pixel-scan request/stream bundle for cell_pixel_scan.
// master drives requests and pix_ready; slave is the scanner.
interface cell_pixel_scan_if;
  logic       start;
  logic [4:0] cell_x;
  logic [4:0] cell_y;
  logic       pix_ready;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_edge;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, cell_x, cell_y, pix_ready,
    input  pix_valid, pix_x, pix_y, pix_edge, busy, done, err
  );

  modport slave (
    input  start, cell_x, cell_y, pix_ready,
    output pix_valid, pix_x, pix_y, pix_edge, busy, done, err
  );
endinterface

// File: rtl/cell_pixel_scan.sv
// Raster-scans the CELL x CELL pixels of one grid cell over a valid/ready stream.
// Define CELL_BORDER_EN to flag border pixels on pix_edge; otherwise pix_edge is tied low.
module cell_pixel_scan #(
  parameter int unsigned CELL    = 20,
  parameter int unsigned MAX_IDX = 19
) (
  input logic          clk,
  input logic          rst_n,
  cell_pixel_scan_if.slave bus
);

  localparam int unsigned OW = $clog2(CELL);
  localparam logic [OW-1:0] Last = OW'(CELL - 1);
  localparam logic [9:0] CellV = 10'(CELL);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q;
  logic [9:0]    base_x_q, base_y_q;
  logic [OW-1:0] off_x_q, off_y_q;
  logic          valid_q, busy_q, done_q, err_q;
  logic [9:0]    pix_x_q, pix_y_q;

  logic [9:0]    start_bx, start_by;
  logic          in_range;
  logic [OW-1:0] nx, ny;
  logic          last_beat;

  // Constant multiply by CELL as a sum of shifted copies of the index.
  function automatic logic [9:0] times_cell(input logic [4:0] i);
    logic [9:0] acc;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      if (CellV[k]) acc = acc + ({5'b0, i} << k);
    end
    return acc;
  endfunction

`ifdef CELL_BORDER_EN
  logic edge_q;

  function automatic logic on_border(input logic [OW-1:0] ox, input logic [OW-1:0] oy);
    return (ox == '0) || (ox == Last) || (oy == '0) || (oy == Last);
  endfunction

  assign bus.pix_edge = edge_q;
`else
  assign bus.pix_edge = 1'b0;
`endif

  always_comb begin
    start_bx  = times_cell(bus.cell_x);
    start_by  = times_cell(bus.cell_y);
    in_range  = (bus.cell_x <= 5'(MAX_IDX)) && (bus.cell_y <= 5'(MAX_IDX));
    nx        = (off_x_q == Last) ? '0 : off_x_q + 1'b1;
    ny        = (off_x_q == Last) ? off_y_q + 1'b1 : off_y_q;
    last_beat = (off_x_q == Last) && (off_y_q == Last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_x_q <= '0;
      base_y_q <= '0;
      off_x_q  <= '0;
      off_y_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
`ifdef CELL_BORDER_EN
      edge_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (in_range) begin
              base_x_q <= start_bx;
              base_y_q <= start_by;
              off_x_q  <= '0;
              off_y_q  <= '0;
              pix_x_q  <= start_bx;
              pix_y_q  <= start_by;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= StScan;
`ifdef CELL_BORDER_EN
              edge_q   <= 1'b1;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StScan: begin
          if (valid_q && bus.pix_ready) begin
            if (last_beat) begin
              valid_q <= 1'b0;
              pix_x_q <= '0;
              pix_y_q <= '0;
              done_q  <= 1'b1;
              state_q <= StDone;
`ifdef CELL_BORDER_EN
              edge_q  <= 1'b0;
`endif
            end else begin
              off_x_q <= nx;
              off_y_q <= ny;
              pix_x_q <= base_x_q + 10'(nx);
              pix_y_q <= base_y_q + 10'(ny);
`ifdef CELL_BORDER_EN
              edge_q  <= on_border(nx, ny);
`endif
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pix_valid = valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cell_pixel_scan.sv
// Self-checking bench for cell_pixel_scan: queue-based pixel model plus literal pins.
module tb_cell_pixel_scan;

  localparam int CELL = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_pixel_scan_if bus ();

  cell_pixel_scan #(.CELL(CELL), .MAX_IDX(19)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [20:0] exp_q[$];  // {x, y, edge} still owed by the DUT
  logic [20:0] acc_q[$];  // beats accepted so far in this scan
  bit          exp_done = 0;
  bit          ready_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic edge_of(input int ox, input int oy);
`ifdef CELL_BORDER_EN
    return (ox == 0) || (ox == CELL - 1) || (oy == 0) || (oy == CELL - 1);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare of DUT outputs against the expected pixel queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_edge, bus.busy, bus.done,
                         bus.err}, 0);
      exp_q.delete();
      exp_done = 0;
    end else begin
      if (exp_done) begin
        chk("done_state", {bus.done, bus.pix_valid, bus.busy}, 3'b101);
        exp_done = 0;
      end else begin
        chk("no_done", bus.done, 0);
      end
      if (bus.pix_valid) begin
        chk("busy_scan", bus.busy, 1);
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("pixel", {bus.pix_x, bus.pix_y, bus.pix_edge}, exp_q[0]);
          if (bus.pix_ready) begin
            acc_q.push_back({bus.pix_x, bus.pix_y, bus.pix_edge});
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1;
          end
        end
      end else begin
        chk("idle_zero", {bus.pix_x, bus.pix_y, bus.pix_edge}, 0);
      end
    end
  end

  task automatic load_model(input int cx, input int cy);
    exp_q.delete();
    acc_q.delete();
    for (int y = 0; y < CELL; y++)
      for (int x = 0; x < CELL; x++)
        exp_q.push_back({10'(cx * CELL + x), 10'(cy * CELL + y), edge_of(x, y)});
  endtask

  task automatic issue_start(input int cx, input int cy);
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.cell_x = 5'(cx);
    bus.cell_y = 5'(cy);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_scan(input int cx, input int cy, input bit rnd);
    int n;
    ready_rand = rnd;
    load_model(cx, cy);
    issue_start(cx, cy);
    @(negedge clk);
    chk("first_latency", bus.pix_valid, 1);
    // A start during the scan must not re-latch the cell.
    #1;
    bus.start  = 1'b1;
    bus.cell_x = 5'd5;
    bus.cell_y = 5'd5;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || exp_done) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("scan_timeout", (n >= 4000), 0);
    @(negedge clk);
    chk("busy_after", {bus.busy, bus.done}, 0);
    chk("beats", acc_q.size(), CELL * CELL);
    ready_rand = 0;
  endtask

  task automatic bad_start(input int cx, input int cy);
    issue_start(cx, cy);
    @(negedge clk);
    chk("err_pulse", {bus.err, bus.pix_valid, bus.busy}, 3'b100);
    @(negedge clk);
    chk("err_clear", {bus.err, bus.pix_valid, bus.busy}, 0);
  endtask

  initial begin
    int n;
    int edges;
    bus.start  = 1'b0;
    bus.cell_x = '0;
    bus.cell_y = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_scan(0, 0, 0);
    chk("c00_first", acc_q[0][20:1], {10'd0, 10'd0});
    chk("c00_last", acc_q[399][20:1], {10'd19, 10'd19});

    run_scan(3, 19, 0);
    chk("c319_first", acc_q[0][20:1], {10'd60, 10'd380});
    chk("c319_20th", acc_q[19][20:1], {10'd79, 10'd380});
    chk("c319_21st", acc_q[20][20:1], {10'd60, 10'd381});
    chk("c319_last", acc_q[399][20:1], {10'd79, 10'd399});

    run_scan(7, 11, 1);
    chk("rnd_first", acc_q[0][20:1], {10'd140, 10'd220});
    chk("rnd_last", acc_q[399][20:1], {10'd159, 10'd239});

    bad_start(20, 5);
    bad_start(0, 31);

    // Abort mid-scan with reset, then a fresh scan must start from scratch.
    load_model(0, 0);
    issue_start(0, 0);
    n = 0;
    while (acc_q.size() < 150 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("abort_timeout", (n >= 1000), 0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle", {bus.pix_valid, bus.busy, bus.done}, 0);
    run_scan(1, 1, 0);
    chk("fresh_first", acc_q[0][20:1], {10'd20, 10'd20});

    run_scan(2, 2, 0);
    edges = 0;
    foreach (acc_q[i]) edges += int'(acc_q[i][0]);
`ifdef CELL_BORDER_EN
    chk("edge_count", edges, 76);
    chk("edge_40_40", acc_q[0], {10'd40, 10'd40, 1'b1});
    chk("edge_59_40", acc_q[19], {10'd59, 10'd40, 1'b1});
    chk("edge_40_59", acc_q[380], {10'd40, 10'd59, 1'b1});
    chk("edge_41_41", acc_q[21], {10'd41, 10'd41, 1'b0});
`else
    chk("edge_count", edges, 0);
    chk("edge_40_40", acc_q[0], {10'd40, 10'd40, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
